// File: rtl/viterbi_traceback_pkg.sv
// viterbi_pkg: shared defaults, FSM encoding and trellis predecessor helper for viterbi_traceback.
package viterbi_pkg;
   localparam int K_DEF = 7;
   localparam int DEPTH_DEF = 32;
   localparam logic [1:0] FILL = 2'd0, TRACE = 2'd1, EMIT = 2'd2;
   // Predecessor of state on a survivor path: shift the decision bit in at the LSB, keep sw bits.
   function automatic logic [31:0] predecessor(input logic [31:0] state, input logic d, input int sw);
      return ((state << 1) | {31'd0, d}) & ((32'd1 << sw) - 32'd1);
   endfunction
endpackage

// File: rtl/viterbi_traceback_if.sv
// viterbi_traceback_if: decision-write, traceback-command and decoded-bit stream signals.
interface viterbi_traceback_if
   import viterbi_pkg::*;
#(
   parameter int K = K_DEF
);
   localparam int NS = 1 << (K - 1);
   logic [NS-1:0] decisions;
   logic we, inReady, tbStart;
   logic [K-2:0] startState;
   logic bitOut, bitValid, outReady, done, overflow;
   modport master (
      output decisions, we, tbStart, startState, outReady,
      input inReady, bitOut, bitValid, done, overflow
   );
   modport slave (
      input decisions, we, tbStart, startState, outReady,
      output inReady, bitOut, bitValid, done, overflow
   );
endinterface

// File: rtl/viterbi_traceback_lifo.sv
// tb_lifo: DEPTH x 1-bit stack that restores chronological bit order; compiled only with TB_REORDER_EN.
`ifdef TB_REORDER_EN
module tb_lifo #(
   parameter int DEPTH = 32
) (
   input logic clk,
   input logic memRst,
   input logic push,
   input logic pop,
   input logic din,
   output logic dout,
   output logic empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);
   logic [DEPTH-1:0] stack;
   logic [AW-1:0] top;
   assign top = level[AW-1:0] - AW'(1);
   assign dout = stack[top];
   assign empty = level == '0;
   always_ff @(posedge clk) begin
      if (!memRst) begin
         level <= '0;
      end else if (push) begin
         stack[level[AW-1:0]] <= din;
         level <= level + (AW+1)'(1);
      end else if (pop) begin
         level <= level - (AW+1)'(1);
      end
   end
endmodule
`endif

// File: rtl/viterbi_traceback.sv
// viterbi_traceback: survivor-decision buffer with on-demand traceback to a valid/ready bit stream.
// Define TB_REORDER_EN to emit bits in chronological order through a LIFO and an EMIT state.
module viterbi_traceback
   import viterbi_pkg::*;
#(
   parameter int K = K_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input logic clk,
   input logic memRst,
   viterbi_traceback_if.slave bus
);
   localparam int SW = K - 1;
   localparam int NS = 1 << SW;
   localparam int AW = $clog2(DEPTH);
   logic [1:0] st;
   logic [AW:0] count, n, cnt_nxt;
   logic [AW-1:0] ptr;
   logic [SW-1:0] cur, cur_nxt;
   logic [NS-1:0] mem [DEPTH];
   logic accept, step, last, finish, done_r, ovf;
   // DEPTH is a power of two, so the top count bit alone marks a full buffer.
   assign bus.inReady = st == FILL && !count[AW];
   assign accept = bus.we && bus.inReady;
   assign cnt_nxt = count + (AW+1)'(accept);
   assign cur_nxt = SW'(predecessor(32'(cur), mem[ptr][cur], SW));
   assign last = n == (AW+1)'(1);
   assign bus.done = done_r;
   assign bus.overflow = ovf;
`ifdef TB_REORDER_EN
   logic lifo_out, lifo_empty, pop;
   logic [AW:0] level;
   assign step = st == TRACE;
   assign pop = st == EMIT && bus.outReady && !lifo_empty;
   assign finish = pop && level == (AW+1)'(1);
   assign bus.bitValid = st == EMIT && !lifo_empty;
   assign bus.bitOut = bus.bitValid && lifo_out;
   tb_lifo #(.DEPTH(DEPTH)) u_lifo (
      .clk, .memRst, .push(step), .pop, .din(cur[SW-1]),
      .dout(lifo_out), .empty(lifo_empty), .level
   );
`else
   assign step = st == TRACE && bus.outReady;
   assign finish = step && last;
   assign bus.bitValid = st == TRACE;
   assign bus.bitOut = bus.bitValid && cur[SW-1];
`endif
   always_ff @(posedge clk) begin
      if (memRst && accept) mem[count[AW-1:0]] <= bus.decisions;
   end
   always_ff @(posedge clk) begin
      if (!memRst) begin
         st <= FILL;
         count <= '0;
         ovf <= 1'b0;
         done_r <= 1'b0;
      end else begin
         done_r <= finish;
         if (finish) begin
            st <= FILL;
            count <= '0;
            ovf <= 1'b0;
         end else if (st == FILL) begin
            count <= cnt_nxt;
            if (bus.we && !bus.inReady) ovf <= 1'b1;
            if (bus.tbStart && cnt_nxt != '0) begin
               cur <= bus.startState;
               ptr <= AW'(cnt_nxt - (AW+1)'(1));
               n <= cnt_nxt;
               st <= TRACE;
            end
         end
         if (step) begin
            cur <= cur_nxt;
            ptr <= ptr - AW'(1);
            n <= n - (AW+1)'(1);
`ifdef TB_REORDER_EN
            if (last) st <= EMIT;
`endif
         end
      end
   end
endmodule

// File: tb/tb_viterbi_traceback.sv
// tb_viterbi_traceback: table, directed and random frames on a K=3/DEPTH=8 and a default K=7/DEPTH=32 instance.
module tb_viterbi_traceback;
   logic clk = 1'b0, rst3 = 1'b0, rst7 = 1'b0;
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   localparam bit REORDER =
`ifdef TB_REORDER_EN
      1'b1;
`else
      1'b0;
`endif
   viterbi_traceback_if #(.K(3)) i3 ();
   viterbi_traceback_if #(.K(7)) i7 ();
   viterbi_traceback #(.K(3), .DEPTH(8)) u3 (.clk(clk), .memRst(rst3), .bus(i3));
   viterbi_traceback u7 (.clk(clk), .memRst(rst7), .bus(i7));
   typedef struct {
      int n;
      logic [31:0] u;
      logic [5:0] s0;
      logic [31:0] rev;
   } vec_t;
   vec_t tbl[4];
   function automatic logic [31:0] v(int sel);
      return 32'(sel != 0 ? i7.bitValid : i3.bitValid);
   endfunction
   function automatic logic [31:0] b(int sel);
      return 32'(sel != 0 ? i7.bitOut : i3.bitOut);
   endfunction
   function automatic logic [31:0] dn(int sel);
      return 32'(sel != 0 ? i7.done : i3.done);
   endfunction
   function automatic logic [31:0] rd(int sel);
      return 32'(sel != 0 ? i7.inReady : i3.inReady);
   endfunction
   function automatic logic [31:0] ov(int sel);
      return 32'(sel != 0 ? i7.overflow : i3.overflow);
   endfunction
   // Reference order: traceback yields u_N..u_1; the reorder build restores u_1..u_N.
   function automatic logic [31:0] order(logic [31:0] u, int n);
      logic [31:0] r = '0;
      for (int i = 0; i < n; i++) r[i] = REORDER ? u[i] : u[n-1-i];
      return r;
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask
   task automatic drive(input int sel, input logic w, input logic [63:0] dec, input logic ts,
                        input logic [5:0] ss, input logic rdy);
      @(posedge clk);
      #1;
      i3.we = 1'b0; i3.tbStart = 1'b0; i7.we = 1'b0; i7.tbStart = 1'b0;
      if (sel == 0) begin
         i3.we = w; i3.decisions = dec[3:0]; i3.tbStart = ts; i3.startState = ss[1:0]; i3.outReady = rdy;
      end else begin
         i7.we = w; i7.decisions = dec; i7.tbStart = ts; i7.startState = ss; i7.outReady = rdy;
      end
      @(negedge clk);
   endtask
   // Encode u from s0 with next = {u, s>>1}; the stored decision at the new state is the bit shifted out.
   task automatic make_frame(input int sel, input int n, input logic [31:0] u, input logic [5:0] s0,
                             input bit merge, output logic [5:0] send);
      int sw = sel != 0 ? 6 : 2;
      logic [5:0] s = s0 & 6'((1 << sw) - 1), sp;
      logic [63:0] dec;
      for (int t = 0; t < n; t++) begin
         sp = s;
         s = 6'((32'(u[t]) << (sw - 1)) | 32'(s >> 1));
         dec = {$urandom, $urandom};
         dec[s] = sp[0];
         drive(sel, 1'b1, dec, merge && t == n - 1, s, 1'b1);
      end
      send = s;
   endtask
   // mode 0: always ready, 1: random ready, 2: ready low for 5 cycles after the third transfer.
   task automatic collect(input int sel, input int n, input logic [31:0] expb, input int mode);
      int got = 0, hold = 0, first = -1;
      bit fin = 0, held = 0;
      logic [31:0] hb = '0;
      logic rdy;
      for (int c = 0; c < 400 && !fin; c++) begin
         rdy = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : !(got >= 3 && hold < 5);
         if (mode == 2 && !rdy) hold++;
         drive(sel, 1'b0, '0, 1'b0, '0, rdy);
         if (held) begin
            chk("hold_valid", v(sel), 1);
            chk("hold_bit", b(sel), hb);
         end
         if (dn(sel) != 0) begin
            fin = 1;
            chk("bit_count", 32'(got), 32'(n));
         end else if (v(sel) != 0) begin
            if (first < 0) begin
               first = c;
               chk("latency", 32'(c), REORDER ? 32'(n) : 32'd0);
            end
            if (rdy) begin
               chk("bit", b(sel), 32'(expb[got[4:0]]));
               got++;
            end
         end
         held = v(sel) != 0 && !rdy;
         hb = b(sel);
      end
      chk("done_seen", 32'(fin), 1);
      drive(sel, 1'b0, '0, 1'b0, '0, 1'b1);
      chk("done_pulse", dn(sel), 0);
      chk("ready_after_done", rd(sel), 1);
      chk("ovf_after_done", ov(sel), 0);
      chk("valid_after_done", v(sel), 0);
   endtask
   initial begin
      logic [5:0] se;
      logic [31:0] u, ord;
      int n;
      bit m;
      tbl[0] = '{4, 32'b1101, 6'd0, 32'b1011};
      tbl[1] = '{1, 32'b1, 6'd3, 32'b1};
      tbl[2] = '{8, 32'b10010110, 6'd1, 32'b01101001};
      tbl[3] = '{3, 32'b110, 6'd2, 32'b011};
      i3.we = 0; i3.tbStart = 0; i3.outReady = 0; i3.decisions = '0; i3.startState = '0;
      i7.we = 0; i7.tbStart = 0; i7.outReady = 0; i7.decisions = '0; i7.startState = '0;
      repeat (3) @(posedge clk);
      #1;
      rst3 = 1'b1;
      rst7 = 1'b1;
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         chk("rst_ready", rd(s), 1);
         chk("rst_valid", v(s), 0);
         chk("rst_bit", b(s), 0);
         chk("rst_done", dn(s), 0);
         chk("rst_ovf", ov(s), 0);
      end
      for (int i = 0; i < 4; i++) begin
         make_frame(0, tbl[i].n, tbl[i].u, tbl[i].s0, 0, se);
         drive(0, 1'b0, '0, 1'b1, se, 1'b1);
         collect(0, tbl[i].n, REORDER ? tbl[i].u : tbl[i].rev, i % 2);
      end
      drive(0, 1'b0, '0, 1'b1, 6'd1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         drive(0, 1'b0, '0, 1'b0, '0, 1'b1);
         chk("empty_start_valid", v(0), 0);
         chk("empty_start_done", dn(0), 0);
         chk("empty_start_ready", rd(0), 1);
      end
      u = 32'b101101;
      ord = order(u, 6);
      make_frame(0, 6, u, 6'd2, 0, se);
      drive(0, 1'b0, '0, 1'b1, se, 1'b1);
      for (int i = 0; i < 3; i++) begin
         drive(0, 1'b0, '0, 1'b0, '0, 1'b1);
         chk("pre_reset_valid", v(0), 32'(!REORDER));
         chk("pre_reset_bit", b(0), REORDER ? 32'd0 : 32'(ord[i]));
      end
      @(posedge clk);
      #1 rst3 = 1'b0;
      @(posedge clk);
      #1 rst3 = 1'b1;
      @(negedge clk);
      chk("post_reset_valid", v(0), 0);
      chk("post_reset_ready", rd(0), 1);
      chk("post_reset_done", dn(0), 0);
      make_frame(0, 4, 32'b0110, 6'd1, 0, se);
      drive(0, 1'b0, '0, 1'b1, se, 1'b1);
      collect(0, 4, order(32'b0110, 4), 0);
      make_frame(0, 4, 32'b1001, 6'd3, 1, se);
      collect(0, 4, order(32'b1001, 4), 0);
      u = $urandom;
      make_frame(1, 32, u, 6'($urandom), 0, se);
      chk("ready_before_full", rd(1), 1);
      drive(1, 1'b0, '0, 1'b0, '0, 1'b1);
      chk("ready_full", rd(1), 0);
      chk("ovf_before", ov(1), 0);
      drive(1, 1'b1, {$urandom, $urandom}, 1'b0, '0, 1'b1);
      drive(1, 1'b0, '0, 1'b0, '0, 1'b1);
      chk("ovf_set", ov(1), 1);
      drive(1, 1'b0, '0, 1'b1, se, 1'b1);
      collect(1, 32, order(u, 32), 1);
      u = $urandom;
      make_frame(1, 10, u, 6'($urandom), 0, se);
      drive(1, 1'b0, '0, 1'b1, se, 1'b1);
      collect(1, 10, order(u, 10), 2);
      for (int i = 0; i < 22; i++) begin
         int sel = i < 16 ? 1 : 0;
         n = $urandom_range(1, sel != 0 ? 32 : 8);
         u = $urandom;
         m = 1'($urandom_range(0, 1));
         make_frame(sel, n, u, 6'($urandom), m, se);
         if (!m) drive(sel, 1'b0, '0, 1'b1, se, 1'b1);
         collect(sel, n, order(u, n), 1);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
